// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation codes
// and the controller state encoding.
package md_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mdState_t;

endpackage

// File: rtl/md_core.sv
// Iterative unsigned datapath for the multiply/divide unit. One radix-2
// step per cycle on a 2*WIDTH accumulator: shift-add for multiply,
// restoring shift-subtract for divide. Works on magnitudes only; signs are
// handled by the caller.
module md_core #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 clrn,
    input  logic                 load,
    input  logic                 step,
    input  logic                 isDiv,
    input  logic [WIDTH-1:0]     magA,
    input  logic [WIDTH-1:0]     magB,
    output logic [2*WIDTH-1:0]   acc,
    output logic                 last
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic             divMode;
    logic [WIDTH-1:0] opnd;
    logic [CNT_W-1:0] count;

    logic [WIDTH-1:0]   hiPart;
    logic [WIDTH-1:0]   loPart;
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divTrial;
    logic [WIDTH:0]     divDiff;
    logic [2*WIDTH-1:0] accNext;

    assign hiPart   = acc[2*WIDTH-1:WIDTH];
    assign loPart   = acc[WIDTH-1:0];
    assign mulSum   = {1'b0, hiPart} + {1'b0, opnd};
    assign divTrial = {hiPart, loPart[WIDTH-1]};
    assign divDiff  = divTrial - {1'b0, opnd};
    assign last     = (count == CNT_W'(WIDTH - 1));

    // One iteration: multiply adds the multiplicand when the low bit is set
    // and shifts right; divide shifts the next dividend bit into the partial
    // remainder and keeps the subtraction only when it does not borrow.
    always_comb begin
        accNext = acc;
        if (divMode) begin
            if (!divDiff[WIDTH]) begin
                accNext = {divDiff[WIDTH-1:0], loPart[WIDTH-2:0], 1'b1};
            end else begin
                accNext = {divTrial[WIDTH-1:0], loPart[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (loPart[0]) begin
                accNext = {mulSum, loPart[WIDTH-1:1]};
            end else begin
                accNext = {1'b0, hiPart, loPart[WIDTH-1:1]};
            end
        end
    end

    // Operand/accumulator load at issue, then one step per CALC cycle.
    // The multiplier (or dividend) sits in the low half and is consumed
    // as the result shifts in.
    always_ff @(posedge clk) begin
        if (load) begin
            divMode <= isDiv;
            opnd    <= isDiv ? magB : magA;
            acc     <= {{WIDTH{1'b0}}, (isDiv ? magA : magB)};
        end else if (step) begin
            acc <= accNext;
        end
    end

    // Iteration counter; last flags the final CALC cycle.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (step) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. Controller FSM
// (IDLE -> CALC -> FIX), operand sign handling, corner-case results and
// the architectural HI/LO registers live here; the iteration is in md_core.
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdState_t state;
    mdState_t nextState;

    logic opIsDiv;
    logic opIsSigned;
    logic accept;
    logic coreStep;
    logic busyNext;
    logic doneNext;

    logic [WIDTH-1:0] magA;
    logic [WIDTH-1:0] magB;

    logic             isDivL;
    logic             isSignedL;
    logic             signAL;
    logic             signBL;
    logic             bZeroL;
    logic [WIDTH-1:0] aRawL;

    logic [2*WIDTH-1:0] acc;
    logic               last;

    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   resHi;
    logic [WIDTH-1:0]   resLo;

    assign opIsDiv    = op[1];
    assign opIsSigned = ~op[0];
    assign accept     = (state == IDLE) && start;

    // Signed operations iterate on magnitudes; MIN maps onto itself, which
    // is the correct unsigned magnitude 2^(WIDTH-1).
    assign magA = (opIsSigned && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign magB = (opIsSigned && b[WIDTH-1]) ? (~b + 1'b1) : b;

    md_core #(.WIDTH(WIDTH)) uCore (
        .clk   (clk),
        .clrn  (clrn),
        .load  (accept),
        .step  (coreStep),
        .isDiv (opIsDiv),
        .magA  (magA),
        .magB  (magB),
        .acc   (acc),
        .last  (last)
    );

    // Issue-time capture of what FIX needs to correct signs and corner cases.
    always_ff @(posedge clk) begin
        if (accept) begin
            isDivL    <= opIsDiv;
            isSignedL <= opIsSigned;
            signAL    <= a[WIDTH-1];
            signBL    <= b[WIDTH-1];
            bZeroL    <= (b == '0);
            aRawL     <= a;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: WIDTH CALC cycles, then a single FIX cycle.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = CALC;
            CALC:    if (last)  nextState = FIX;
            FIX:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Controller outputs, computed one cycle ahead so busy/done are registered.
    always_comb begin
        coreStep = (state == CALC);
        busyNext = (nextState != IDLE);
        doneNext = (state == FIX);
    end

    // Sign correction and corner-case selection of the final result.
    always_comb begin
        product = acc;
        if (isSignedL && (signAL ^ signBL)) begin
            product = ~acc + 1'b1;
        end
        quot = acc[WIDTH-1:0];
        rem  = acc[2*WIDTH-1:WIDTH];
        if (isSignedL && (signAL ^ signBL)) begin
            quot = ~quot + 1'b1;
        end
        if (isSignedL && signAL) begin
            rem = ~rem + 1'b1;
        end
        if (!isDivL) begin
            resHi = product[2*WIDTH-1:WIDTH];
            resLo = product[WIDTH-1:0];
        end else if (bZeroL) begin
            resHi = aRawL;
            resLo = '1;
        end else begin
            resHi = rem;
            resLo = quot;
        end
    end

    // Registered status and HI/LO: results land at the end of FIX, mthi/mtlo
    // only in IDLE and only when no operation is being issued.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            busy <= 1'b0;
            done <= 1'b0;
            dz   <= 1'b0;
            hi   <= '0;
            lo   <= '0;
        end else begin
            busy <= busyNext;
            done <= doneNext;
            if (state == FIX) begin
                hi <= resHi;
                lo <= resLo;
                dz <= isDivL && bZeroL;
            end else if ((state == IDLE) && !start) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit (WIDTH=32) with a scoreboard of expected
// HI/LO/dz results pushed at issue and popped on done.
module tb_md_unit;
    import md_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         clrn;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic         dz;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    md_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .clrn  (clrn),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        tag;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    int   nAssert = 0;
    int   nFail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input string tag, input logic [W-1:0] eh, input logic [W-1:0] el,
                         input logic ed);
        exp_t e;
        e.tag = tag; e.hi = eh; e.lo = el; e.dz = ed;
        sb.push_back(e);
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, ":busy"}, 64'(busy), 64'd1);
    endtask

    // n0: edges already elapsed since the issue edge.
    task automatic waitDone(input int n0);
        int   n;
        exp_t e;
        n = n0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (sb.size() == 0) begin
            check("scoreboard_empty", 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            check({e.tag, ":latency"}, 64'(n), 64'(W + 1));
            check({e.tag, ":hi"}, 64'(hi), 64'(e.hi));
            check({e.tag, ":lo"}, 64'(lo), 64'(e.lo));
            check({e.tag, ":dz"}, 64'(dz), 64'(e.dz));
            check({e.tag, ":busy_in_done"}, 64'(busy), 64'd0);
        end
    endtask

    initial begin
        logic [63:0]        p;
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        logic signed [63:0] sp;
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sbv;
        logic signed [W-1:0] sq;
        logic signed [W-1:0] sr;
        logic [W-1:0]        x;
        logic [W-1:0]        y;

        clrn = 1'b0; start = 1'b0; op = MD_MULT; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst:hi", 64'(hi), 64'd0);
        check("rst:lo", 64'(lo), 64'd0);
        check("rst:busy", 64'(busy), 64'd0);
        check("rst:done", 64'(done), 64'd0);
        check("rst:dz", 64'(dz), 64'd0);
        @(negedge clk);
        clrn = 1'b1;
        tick();

        // Signed multiply with mixed signs: -3 * 7 = -21
        issue(MD_MULT, 32'hFFFFFFFD, 32'd7, "mult_neg", 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        waitDone(0);

        // Unsigned max square, then back-to-back signed divide -7 / 2
        issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max", 32'hFFFFFFFE, 32'h00000001, 1'b0);
        waitDone(0);
        issue(MD_DIV, 32'hFFFFFFF9, 32'd2, "div_b2b", 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        waitDone(0);

        // Divide by zero sets dz; next multiply clears it
        issue(MD_DIVU, 32'h64, 32'd0, "divu_zero", 32'h00000064, 32'hFFFFFFFF, 1'b1);
        waitDone(0);
        issue(MD_MULTU, 32'd2, 32'd3, "multu_clr_dz", 32'd0, 32'd6, 1'b0);
        waitDone(0);

        // Signed overflow case MIN / -1
        issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF, "div_min_m1", 32'd0, 32'h80000000, 1'b0);
        waitDone(0);

        // Positive dividend, negative divisor: 7 / -2 = -3 rem 1
        issue(MD_DIV, 32'd7, 32'hFFFFFFFE, "div_pos_neg", 32'd1, 32'hFFFFFFFD, 1'b0);
        waitDone(0);

        // start and mthi while busy are ignored
        issue(MD_DIVU, 32'd100, 32'd7, "divu_ignore", 32'd2, 32'd14, 1'b0);
        repeat (4) tick();
        start = 1'b1; op = MD_MULT; a = 32'd3; b = 32'd3; hi_we = 1'b1; wdata = 32'h1234;
        tick();
        start = 1'b0; hi_we = 1'b0;
        waitDone(5);
        tick();
        check("done_pulse_width", 64'(done), 64'd0);

        // mtlo / mthi in IDLE take one edge
        lo_we = 1'b1; wdata = 32'hABCD;
        tick();
        lo_we = 1'b0;
        check("mtlo:lo", 64'(lo), 64'h0000ABCD);
        check("mtlo:hi_kept", 64'(hi), 64'd2);
        hi_we = 1'b1; wdata = 32'h5555;
        tick();
        hi_we = 1'b0;
        check("mthi:hi", 64'(hi), 64'h00005555);

        // start together with mthi: start wins
        hi_we = 1'b1; wdata = 32'h1234;
        issue(MD_MULTU, 32'd5, 32'd5, "start_wins", 32'd0, 32'd25, 1'b0);
        hi_we = 1'b0;
        waitDone(0);

        // Random operands against a reference computed from SV arithmetic
        for (int i = 0; i < 3; i++) begin
            x = $urandom; y = $urandom;
            p = {32'd0, x} * {32'd0, y};
            issue(MD_MULTU, x, y, "rnd_multu", p[63:32], p[31:0], 1'b0);
            waitDone(0);

            sx = $signed(x); sy = $signed(y);
            sp = sx * sy;
            issue(MD_MULT, x, y, "rnd_mult", sp[63:32], sp[31:0], 1'b0);
            waitDone(0);

            y = $urandom_range(65535, 1);
            issue(MD_DIVU, x, y, "rnd_divu", x % y, x / y, 1'b0);
            waitDone(0);

            sa = $signed(x);
            sbv = $signed(y);
            if (i[0]) sbv = -sbv;
            sq = sa / sbv;
            sr = sa % sbv;
            issue(MD_DIV, sa, sbv, "rnd_div", sr, sq, 1'b0);
            waitDone(0);
        end

        // Async reset in the middle of CALC discards the operation
        op = MD_MULTU; a = 32'd7; b = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        #2;
        clrn = 1'b0;
        #1;
        check("midrst:busy", 64'(busy), 64'd0);
        check("midrst:done", 64'(done), 64'd0);
        check("midrst:hi", 64'(hi), 64'd0);
        check("midrst:lo", 64'(lo), 64'd0);
        @(negedge clk);
        clrn = 1'b1;
        tick();
        issue(MD_MULTU, 32'd7, 32'd9, "after_rst", 32'd0, 32'd63, 1'b0);
        waitDone(0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
